fetch_unit: RTL

Instruction fetch stage that sits directly upstream of decode in the pipelined 16-bit CPU. It owns the fetch PC, issues requests to a multi-cycle instruction memory over a req/ack handshake, and buffers returned words in a small prefetch queue. It presents instructions to decode with a valid/ready handshake. On a branch, jump, jr or jal redirect it flushes the queue and discards stale memory responses.

---
 rtl/fetch_unit.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage for the pipelined 16-bit CPU. It owns the fetch PC,
// issues word requests to a multi-cycle instruction memory over a req/ack
// handshake and buffers the returned words in a small circular prefetch queue
// that feeds decode through a valid/ready handshake. A redirect (branch, jump,
// jr, jal) flushes the queue and discards the response of any request that
// was already in flight.
//
// Parameters:
//   DEPTH     prefetch queue entries (power of 2, at least 2)
//   RESET_PC  fetch PC after reset
//
// Ports:
//   clk           clock, all state updates on the rising edge
//   rst           asynchronous active-low reset
//   mem_req       registered memory request
//   mem_addr      registered word address of the request
//   mem_ack       memory accepts the request and returns data this cycle
//   mem_rdata     instruction word, valid when mem_req && mem_ack
//   inst_valid    queue head holds a valid instruction
//   inst          instruction at the queue head (0 when empty)
//   inst_pc       address of inst (0 when empty)
//   inst_next_pc  inst_pc + 1, wrapping at 16 bits (0 when empty)
//   inst_ready    decode consumes the head this cycle
//   redirect      flush and restart fetch
//   redirect_pc   new fetch address, sampled when redirect = 1
// ----------------------------------------------------------------------------
module fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        inst_valid,
    output logic [15:0] inst,
    output logic [15:0] inst_pc,
    output logic [15:0] inst_next_pc,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [15:0] redirect_pc
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    // IDLE: nothing outstanding. WAIT: request outstanding, its data is
    // wanted. DROP: request outstanding, but a redirect made it stale.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [15:0]   fetch_pc, fetch_pc_n;
    logic          mem_req_n;
    logic [15:0]   mem_addr_n;

    logic [15:0]   q_inst [DEPTH];
    logic [15:0]   q_pc   [DEPTH];
    logic [AW-1:0] head, tail;
    logic [CW-1:0] count, count_next;

    logic          transfer;
    logic          push;
    logic          pop;
    logic          credit;
    logic [15:0]   seq_addr;

    // ------------------------------------------------------------------------
    // Handshake qualifiers
    // ------------------------------------------------------------------------
    assign transfer = mem_req && mem_ack;
    // Only data for a live request in WAIT is kept; redirect overrides both
    // the push and the pop of the same cycle.
    assign push     = transfer && (state == WAIT) && !redirect;
    assign pop      = inst_valid && inst_ready && !redirect;
    assign seq_addr = mem_addr + 16'd1;

    always_comb begin
        // NOTE: every signal written in a combinational block gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        count_next = count;
        if (redirect) begin
            count_next = '0;
        end else begin
            count_next = count + CW'(push) - CW'(pop);
        end
    end

    // A new request is allowed only if a slot is guaranteed for its data,
    // counting this cycle's push and pop, so the queue can never overflow.
    assign credit = (count_next < DEPTH_CNT);

    // ------------------------------------------------------------------------
    // Fetch FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            mem_req  <= 1'b0;
            mem_addr <= '0;
        end else begin
            state    <= state_n;
            fetch_pc <= fetch_pc_n;
            mem_req  <= mem_req_n;
            mem_addr <= mem_addr_n;
        end
    end

    // ------------------------------------------------------------------------
    // Fetch FSM: next state and registered request outputs.
    // mem_req/mem_addr only change from their held values in IDLE or on a
    // transfer, so an issued request is never withdrawn or altered.
    // ------------------------------------------------------------------------
    always_comb begin
        state_n    = state;
        fetch_pc_n = fetch_pc;
        mem_req_n  = mem_req;
        mem_addr_n = mem_addr;

        case (state)
            IDLE: begin
                if (redirect) begin
                    // The flush empties the queue, so credit always holds
                    // here and the new target is requested straight away.
                    fetch_pc_n = redirect_pc;
                    mem_req_n  = 1'b1;
                    mem_addr_n = redirect_pc;
                    state_n    = WAIT;
                end else if (credit) begin
                    mem_req_n  = 1'b1;
                    mem_addr_n = fetch_pc;
                    state_n    = WAIT;
                end
            end

            WAIT: begin
                if (transfer) begin
                    if (redirect) begin
                        // Returned word is discarded; request drops for a
                        // cycle and IDLE then fetches the redirect target.
                        fetch_pc_n = redirect_pc;
                        mem_req_n  = 1'b0;
                        state_n    = IDLE;
                    end else begin
                        fetch_pc_n = seq_addr;
                        if (credit) begin
                            // Back-to-back: one instruction per cycle with a
                            // zero-wait memory.
                            mem_req_n  = 1'b1;
                            mem_addr_n = seq_addr;
                        end else begin
                            mem_req_n = 1'b0;
                            state_n   = IDLE;
                        end
                    end
                end else if (redirect) begin
                    // Request must stay up until accepted; its data is
                    // thrown away from DROP.
                    fetch_pc_n = redirect_pc;
                    state_n    = DROP;
                end
            end

            DROP: begin
                // Further redirects only retarget; the last one wins.
                if (redirect) begin
                    fetch_pc_n = redirect_pc;
                end
                if (transfer) begin
                    if (credit) begin
                        mem_req_n  = 1'b1;
                        mem_addr_n = redirect ? redirect_pc : fetch_pc;
                        state_n    = WAIT;
                    end else begin
                        mem_req_n = 1'b0;
                        state_n   = IDLE;
                    end
                end
            end

            default: begin
                mem_req_n = 1'b0;
                state_n   = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Prefetch queue storage
    // ------------------------------------------------------------------------
    // NOTE: the storage array is not reset; occupancy is tracked by
    // head/tail/count and the outputs are masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            q_inst[tail] <= mem_rdata;
            q_pc[tail]   <= mem_addr;
        end
    end

    // ------------------------------------------------------------------------
    // Prefetch queue pointers. DEPTH is a power of 2, so the pointers wrap
    // naturally at their width.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (redirect) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PTR_ONE;
            end
            if (pop) begin
                head <= head + PTR_ONE;
            end
            count <= count_next;
        end
    end

    // ------------------------------------------------------------------------
    // Decode-facing outputs, straight from the head entry
    // ------------------------------------------------------------------------
    assign inst_valid   = (count != '0);
    assign inst         = inst_valid ? q_inst[head] : '0;
    assign inst_pc      = inst_valid ? q_pc[head] : '0;
    assign inst_next_pc = inst_valid ? (q_pc[head] + 16'd1) : '0;

endmodule
